control_pipe: RTL
=================

Name: control_pipe

Overview:
- Consumer end of the main decoder's control bundle.
- Registers the ID-stage control word and register indices through the ID/EX, EX/MEM and MEM/WB boundaries, and fans the stage-appropriate fields out to the EX, MEM and WB datapaths.
- Owns hazard handling for the 5-stage RV32I pipeline: load-use stall, bubble insertion, and IF/ID + ID/EX flush on an EX-resolved redirect.
- Sits between the main decoder and the datapath pipeline registers.

Parameters:
- REG_ADDR_W, 5: register index width.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_ctrl  in  10  decoded control word, packed {JumpReg, Jump, Branch, ALUOp[1:0], MemWrite, MemRead, RegWrite, MemtoReg, ALUSrc}.
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  ID-stage register indices.
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1 / rs2.
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- ex_ctrl  out  10  ID/EX control word.
- ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_W  ID/EX indices.
- mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg  out  1  EX/MEM control fields.
- mem_rd  out  REG_ADDR_W  EX/MEM destination.
- wb_regwrite, wb_memtoreg  out  1  MEM/WB control fields.
- wb_rd  out  REG_ADDR_W  MEM/WB destination.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clear.
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 10 EX/MEM, 01 MEM/WB.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All stage registers cleared to bubble: ctrl=0, rs/rd=0.
  - stall_cnt=0.
  - Combinational outputs settle to pc_write=1, ifid_write=1, ifid_flush=0, fwd=00.
  - Reset asserted mid-stall or mid-flush discards all in-flight state.
- Per-stage contents, each rising edge:
  - MEM/WB <= EX/MEM fields.
  - EX/MEM <= ID/EX fields (MemRead, MemWrite, RegWrite, MemtoReg, rd).
  - ID/EX <= id_* or a bubble.
- Latency: an ID field appears on ex_* after 1 cycle, mem_* after 2, wb_* after 3.
- Hazard term, match(r): r != 0 and r == ex_rd and ex_ctrl.RegWrite.
- load_use = ex_ctrl.MemRead and ((id_use_rs1 and match(id_rs1)) or (id_use_rs2 and match(id_rs2))).
- stall = load_use (set extended under FORWARD_EN off, below).
- Stall cycle:
  - pc_write=0, ifid_write=0.
  - ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.
  - A stall lasts exactly one cycle per load-use, because the bubble removes the match.
- Redirect (ex_redirect=1):
  - ifid_flush=1; ID/EX loads a bubble next edge.
  - pc_write=1, ifid_write=1 (PC takes the target).
  - Redirect has priority over stall; a simultaneous stall is suppressed and not counted.
  - The instruction in EX itself advances to MEM (a jump's link write completes).
- x0: rd=0 never causes a stall or a forward.
- stall_cnt: increments on each stall cycle, saturates at all-ones, never wraps.

Optional Feature:
- Macro: CONTROL_PIPE_FORWARD_EN.
- Defined:
  - fwd_a is computed for ex_rs1 and fwd_b for ex_rs2.
  - Select 10 when mem_regwrite, mem_rd != 0 and mem_rd == ex_rsN.
  - Else select 01 when wb_regwrite, wb_rd != 0 and wb_rd == ex_rsN.
  - Else 00. EX/MEM has priority over MEM/WB.
  - Only load-use stalls.
- Undefined:
  - fwd_a and fwd_b are tied to 00.
  - stall additionally asserts on any used rs that matches a RegWrite rd != 0 in ID/EX or EX/MEM.
  - The register file is write-before-read, so there is no WB-stage check.

Decomposition:
- Package control_pipe_pkg holds:
  - ctrl_t, a packed struct in the id_ctrl bit order.
  - CTRL_BUBBLE constant (all zero).
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}.
- One sub-module: hazard_unit (combinational).
  - Computes stall, pc_write, ifid_write, ifid_flush, fwd_a and fwd_b.
  - Takes ID inputs and stage-register outputs.
  - Pipeline registers and counter stay in the top.

Test Plan:
- Pipe propagation: id_ctrl=10'h00E with RegWrite, rd=5, no hazards -> ex_ctrl=10'h00E at cycle 1, mem_regwrite=1/mem_rd=5 at cycle 2, wb_regwrite=1/wb_rd=5 at cycle 3.
- Load-use: lw x5 in EX, then ID add with rs1=5 and use_rs1=1 -> one cycle with pc_write=0, ifid_write=0 and ex_ctrl=0 next; stall_cnt=1; then the add enters EX with fwd_a=01 (forwarding build).
- Load to x0: lw x0 in EX, ID uses rs1=0 -> no stall, stall_cnt unchanged.
- Redirect during load-use: ex_redirect=1 concurrent with a load-use match -> ifid_flush=1, pc_write=1, ID/EX bubble, stall_cnt unchanged.
- Forward priority (macro on): mem_rd=7 and wb_rd=7 both writing, ex_rs2=7 -> fwd_b=10. Macro off: ID rs1=7 with EX rd=7 RegWrite -> stall.
- Async reset asserted mid-stall with stall_cnt=3 -> all outputs at reset values immediately, stall_cnt=0; the first post-reset edge loads id_* normally.

Source files
------------

// File: rtl/control_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_pipe_pkg
// Description : Shared types for the control pipeline.
//               ctrl_t      - decoded control word, in id_ctrl bit order
//                             {JumpReg, Jump, Branch, ALUOp[1:0], MemWrite,
//                              MemRead, RegWrite, MemtoReg, ALUSrc}
//               CTRL_BUBBLE - all-zero control word (a pipeline bubble)
//               fwd_sel_t   - EX operand source select encoding
// Revision    : 1.0 - initial release
// ============================================================================
package control_pipe_pkg;

   localparam int CTRL_W = 10;

   typedef struct packed {
      logic       jump_reg;
      logic       jump;
      logic       branch;
      logic [1:0] alu_op;
      logic       mem_write;
      logic       mem_read;
      logic       reg_write;
      logic       mem_to_reg;
      logic       alu_src;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

endpackage
`default_nettype wire

// File: rtl/control_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Combinational hazard detection and operand forwarding select
//               for the 5-stage pipeline.
//               Optional feature macro: CONTROL_PIPE_FORWARD_EN
//                 defined   - EX/MEM and MEM/WB forwarding; only load-use stalls
//                 undefined - no forwarding; any RAW against ID/EX or EX/MEM
//                             stalls (register file is write-before-read)
// Ports       : ex_redirect          branch/jump resolved in EX
//               id_rs1/id_rs2        ID source indices
//               id_use_rs1/id_use_rs2 ID instruction reads rs1/rs2
//               ex_memread/regwrite  ID/EX control bits
//               ex_rs1/ex_rs2/ex_rd  ID/EX indices
//               mem_regwrite/mem_rd  EX/MEM write-back destination
//               wb_regwrite/wb_rd    MEM/WB write-back destination
//               stall                effective stall (already masked by redirect)
//               pc_write/ifid_write  PC and IF/ID load enables
//               ifid_flush           IF/ID clear
//               fwd_a/fwd_b          EX operand select
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
   import control_pipe_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  ex_redirect,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic                  ex_memread,
   input  logic                  ex_regwrite,
   input  logic [REG_ADDR_W-1:0] ex_rs1,
   input  logic [REG_ADDR_W-1:0] ex_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  mem_regwrite,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  wb_regwrite,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  stall,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b
);

   localparam logic [REG_ADDR_W-1:0] X0 = '0;

   logic     rs1_ex_hit;
   logic     rs2_ex_hit;
   logic     load_use;
   logic     hazard;
   fwd_sel_t sel_a;
   fwd_sel_t sel_b;

   // A source only counts as dependent when the instruction really reads it
   // and the producer writes a register other than x0.
   assign rs1_ex_hit = id_use_rs1 && ex_regwrite && (ex_rd != X0) && (id_rs1 == ex_rd);
   assign rs2_ex_hit = id_use_rs2 && ex_regwrite && (ex_rd != X0) && (id_rs2 == ex_rd);
   assign load_use   = ex_memread && (rs1_ex_hit || rs2_ex_hit);

`ifdef CONTROL_PIPE_FORWARD_EN
   // EX/MEM holds the younger result, so it wins over MEM/WB.
   always_comb begin
      sel_a = FWD_RF;
      sel_b = FWD_RF;
      if (mem_regwrite && (mem_rd != X0) && (mem_rd == ex_rs1)) begin
         sel_a = FWD_MEM;
      end else if (wb_regwrite && (wb_rd != X0) && (wb_rd == ex_rs1)) begin
         sel_a = FWD_WB;
      end
      if (mem_regwrite && (mem_rd != X0) && (mem_rd == ex_rs2)) begin
         sel_b = FWD_MEM;
      end else if (wb_regwrite && (wb_rd != X0) && (wb_rd == ex_rs2)) begin
         sel_b = FWD_WB;
      end
   end

   assign hazard = load_use;
`else
   logic rs1_mem_hit;
   logic rs2_mem_hit;
   logic unused_fwd_inputs;

   assign rs1_mem_hit = id_use_rs1 && mem_regwrite && (mem_rd != X0) && (id_rs1 == mem_rd);
   assign rs2_mem_hit = id_use_rs2 && mem_regwrite && (mem_rd != X0) && (id_rs2 == mem_rd);

   // Without forwarding, the consumer waits until the producer reaches WB;
   // the write-before-read register file then supplies the value.
   assign hazard = load_use || rs1_ex_hit || rs2_ex_hit || rs1_mem_hit || rs2_mem_hit;

   assign sel_a = FWD_RF;
   assign sel_b = FWD_RF;

   assign unused_fwd_inputs = ^{ex_rs1, ex_rs2, wb_regwrite, wb_rd};
`endif

   // A redirect squashes the ID instruction anyway, so holding it is pointless.
   assign stall      = hazard && !ex_redirect;
   assign pc_write   = !stall;
   assign ifid_write = !stall;
   assign ifid_flush = ex_redirect;
   assign fwd_a      = sel_a;
   assign fwd_b      = sel_b;

endmodule
`default_nettype wire

// File: rtl/control_pipe.sv
`default_nettype none
// ============================================================================
// Module      : control_pipe
// Description : Control-word pipeline (ID/EX, EX/MEM, MEM/WB) with hazard
//               handling for a 5-stage RV32I core: load-use stall, bubble
//               insertion, IF/ID + ID/EX flush on an EX-resolved redirect,
//               and a saturating stall-cycle counter.
//               Optional feature macro: CONTROL_PIPE_FORWARD_EN (forwarding).
// Ports       : clk, rst_n                 clock, async active-low reset
//               id_ctrl                    decoded ID control word
//               id_rs1/id_rs2/id_rd        ID register indices
//               id_use_rs1/id_use_rs2      ID instruction reads rs1/rs2
//               ex_redirect                branch taken / jump in EX
//               ex_ctrl, ex_rs1/rs2/rd     ID/EX stage contents
//               mem_memread/memwrite/
//               mem_regwrite/memtoreg/rd   EX/MEM stage contents
//               wb_regwrite/memtoreg/rd    MEM/WB stage contents
//               pc_write, ifid_write       fetch-side load enables
//               ifid_flush                 IF/ID clear
//               fwd_a, fwd_b               EX operand select
//               stall_cnt                  saturating stall-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module control_pipe
   import control_pipe_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CTRL_W-1:0]     id_ctrl,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic                  ex_redirect,
   output logic [CTRL_W-1:0]     ex_ctrl,
   output logic [REG_ADDR_W-1:0] ex_rs1,
   output logic [REG_ADDR_W-1:0] ex_rs2,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  mem_memread,
   output logic                  mem_memwrite,
   output logic                  mem_regwrite,
   output logic                  mem_memtoreg,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  wb_regwrite,
   output logic                  wb_memtoreg,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   ctrl_t ex_word;
   logic  stall;
   logic  insert_bubble;

   assign ex_ctrl = ex_word;

   // Both a stall and a redirect leave nothing valid to issue into EX.
   assign insert_bubble = stall || ex_redirect;

   hazard_unit #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard (
      .ex_redirect  (ex_redirect),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .ex_memread   (ex_word.mem_read),
      .ex_regwrite  (ex_word.reg_write),
      .ex_rs1       (ex_rs1),
      .ex_rs2       (ex_rs2),
      .ex_rd        (ex_rd),
      .mem_regwrite (mem_regwrite),
      .mem_rd       (mem_rd),
      .wb_regwrite  (wb_regwrite),
      .wb_rd        (wb_rd),
      .stall        (stall),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .ifid_flush   (ifid_flush),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b)
   );

   // ID/EX: load the decoded instruction or a bubble (ctrl and indices zero).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_word <= CTRL_BUBBLE;
         ex_rs1  <= '0;
         ex_rs2  <= '0;
         ex_rd   <= '0;
      end else if (insert_bubble) begin
         ex_word <= CTRL_BUBBLE;
         ex_rs1  <= '0;
         ex_rs2  <= '0;
         ex_rd   <= '0;
      end else begin
         ex_word <= ctrl_t'(id_ctrl);
         ex_rs1  <= id_rs1;
         ex_rs2  <= id_rs2;
         ex_rd   <= id_rd;
      end
   end

   // EX/MEM: always advances, so the instruction in EX completes even when
   // it is the one that caused a redirect (jump link write).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_memread  <= 1'b0;
         mem_memwrite <= 1'b0;
         mem_regwrite <= 1'b0;
         mem_memtoreg <= 1'b0;
         mem_rd       <= '0;
      end else begin
         mem_memread  <= ex_word.mem_read;
         mem_memwrite <= ex_word.mem_write;
         mem_regwrite <= ex_word.reg_write;
         mem_memtoreg <= ex_word.mem_to_reg;
         mem_rd       <= ex_rd;
      end
   end

   // MEM/WB: always advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_regwrite <= 1'b0;
         wb_memtoreg <= 1'b0;
         wb_rd       <= '0;
      end else begin
         wb_regwrite <= mem_regwrite;
         wb_memtoreg <= mem_memtoreg;
         wb_rd       <= mem_rd;
      end
   end

   // Stall counter sticks at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire
